// File: rtl/uart_rx_image_loader.sv
// rtl/uart_rx_image_loader.sv - sequences the oversampling UART receiver to load one image into frame-buffer BRAM
module uart_rx_image_loader #(
   parameter int                    BAUD_DIV      = 54,
   parameter int                    DATA_WIDTH    = 8,
   parameter int                    IMG_WIDTH     = 64,
   parameter int                    IMG_HEIGHT    = 64,
   parameter int                    ADDR_WIDTH    = 12,
   parameter logic [DATA_WIDTH-1:0] SYNC_BYTE     = 8'hA5,
   parameter int                    TIMEOUT_TICKS = 4096
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   output logic                  o_rx_en,
   output logic                  o_rx_reset,
   input  logic [DATA_WIDTH-1:0] i_rx_data,
   input  logic                  i_rx_data_valid,
   output logic                  o_wr_en,
   output logic [ADDR_WIDTH-1:0] o_wr_addr,
   output logic [DATA_WIDTH-1:0] o_wr_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err_timeout
);

   localparam int DIV_W  = $clog2(BAUD_DIV);
   localparam int TICK_W = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(BAUD_DIV - 1);
   localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(TIMEOUT_TICKS - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_LOAD, ST_DONE} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [DIV_W-1:0]      div_cnt;
   logic                  valid_q;
   logic                  accept;
   logic                  sync_hit;
   logic                  timeout_hit;
   logic                  last_pix;
   logic [ADDR_WIDTH-1:0] pix_idx;
   logic [TICK_W-1:0]     tick_cnt;

   assign o_rx_en     = (div_cnt == DIV_LAST);
   assign accept      = i_rx_data_valid & ~valid_q;
   assign sync_hit    = accept & (i_rx_data == SYNC_BYTE);
   assign last_pix    = (pix_idx == LAST_IDX);
   // an accept in the same cycle as the final tick rescues the frame
   assign timeout_hit = (state == ST_LOAD) & o_rx_en & ~accept & (tick_cnt == TICK_LAST);

   // free-running oversample divider; keeps running while idle so the receiver sees its reset
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // delayed copy of the receiver valid level for rising-edge detection
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= i_rx_data_valid;
      end
   end

   // state register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (i_start) state_nxt = ST_SYNC;
         ST_SYNC: if (sync_hit) state_nxt = ST_LOAD;
         ST_LOAD: begin
            if (accept && last_pix) begin
               state_nxt = ST_DONE;
            end else if (timeout_hit) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      o_busy     = 1'b0;
      o_rx_reset = 1'b1;
      if (state == ST_SYNC || state == ST_LOAD) begin
         o_busy     = 1'b1;
         o_rx_reset = 1'b0;
      end
   end

   // pixel index, inter-byte tick counter, BRAM write port and status flags
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pix_idx       <= '0;
         tick_cnt      <= '0;
         o_wr_en       <= 1'b0;
         o_wr_addr     <= '0;
         o_wr_data     <= '0;
         o_done        <= 1'b0;
         o_err_timeout <= 1'b0;
      end else begin
         o_wr_en <= 1'b0;
         o_done  <= (state == ST_DONE);
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  o_err_timeout <= 1'b0;
                  pix_idx       <= '0;
               end
            end
            ST_SYNC: begin
               if (sync_hit) tick_cnt <= '0;
            end
            ST_LOAD: begin
               if (accept) begin
                  o_wr_en   <= 1'b1;
                  o_wr_addr <= pix_idx;
                  o_wr_data <= i_rx_data;
                  pix_idx   <= pix_idx + ADDR_WIDTH'(1);
                  tick_cnt  <= '0;
               end else if (timeout_hit) begin
                  o_err_timeout <= 1'b1;
               end else if (o_rx_en) begin
                  tick_cnt <= tick_cnt + TICK_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_image_loader.sv
// tb/tb_uart_rx_image_loader.sv - self-checking bench for uart_rx_image_loader
module tb_uart_rx_image_loader;

   localparam int BD   = 4;
   localparam int IW   = 4;
   localparam int IH   = 2;
   localparam int TO   = 20;
   localparam int AW   = 12;
   localparam int DW   = 8;
   localparam int NPIX = IW * IH;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          rx_en, rx_reset, wr_en, busy, done, err;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   uart_rx_image_loader #(
      .BAUD_DIV(BD), .DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH),
      .ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_TICKS(TO)
   ) dut (
      .i_clk(clk), .i_reset(rst), .i_start(start),
      .o_rx_en(rx_en), .o_rx_reset(rx_reset),
      .i_rx_data(rx_data), .i_rx_data_valid(rx_valid),
      .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
      .o_busy(busy), .o_done(done), .o_err_timeout(err)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   logic rst_q = 1'b1;

   // model: phase 0 idle, 1 waiting for sync, 2 loading
   int                phase = 0;
   int                idx = 0;
   int                last_acc = 0;
   logic [AW+DW-1:0]  exp_wr[int];
   bit                done_at[int];
   bit                busy_at[int];
   bit                err_at[int];
   bit                m_busy = 0;
   bit                m_err = 0;

   int                nwr = 0;
   int                ndone = 0;
   logic [DW-1:0]     wlog[int];
   logic [15:0]       pat = '0;
   bit                pat_done = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) begin
      rst_q <= rst;
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // compare process: DUT outputs against the scheduled model every cycle
   always @(negedge clk) begin
      if (rst_q) begin
         exp_wr.delete(); done_at.delete(); busy_at.delete(); err_at.delete();
         m_busy = 0;
         m_err  = 0;
      end
      if (busy_at.exists(cyc)) m_busy = busy_at[cyc];
      if (err_at.exists(cyc))  m_err  = err_at[cyc];
      if (!pat_done && cyc < 16) pat[cyc] = rx_en;
      chk("rx_en", {31'd0, rx_en}, {31'd0, (cyc % BD) == BD - 1});
      chk("wr_en", {31'd0, wr_en}, {31'd0, exp_wr.exists(cyc)});
      if (wr_en && exp_wr.exists(cyc)) begin
         chk("wr_addr", {20'd0, wr_addr}, {20'd0, exp_wr[cyc][AW+DW-1:DW]});
         chk("wr_data", {24'd0, wr_data}, {24'd0, exp_wr[cyc][DW-1:0]});
      end
      if (wr_en) begin
         nwr++;
         wlog[int'(wr_addr)] = wr_data;
      end
      if (done) ndone++;
      chk("done", {31'd0, done}, {31'd0, done_at.exists(cyc)});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("rx_reset", {31'd0, rx_reset}, {31'd0, !m_busy});
      chk("err_timeout", {31'd0, err}, {31'd0, m_err});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_accept(input logic [DW-1:0] b, input int n);
      if (phase == 1) begin
         if (b == 8'hA5) begin
            phase    = 2;
            idx      = 0;
            last_acc = n;
         end
      end else if (phase == 2) begin
         exp_wr[n + 1] = {AW'(idx), b};
         idx++;
         last_acc = n;
         if (idx == NPIX) begin
            busy_at[n + 1] = 0;
            done_at[n + 2] = 1;
            phase = 0;
         end
      end
   endtask

   task automatic send_byte(input logic [DW-1:0] b, input int hold = 8);
      rx_data  = b;
      rx_valid = 1'b1;
      model_accept(b, cyc);
      repeat (hold) tick();
      rx_valid = 1'b0;
      repeat (4) tick();
   endtask

   task automatic pulse_start();
      if (phase == 0) begin
         busy_at[cyc + 1] = 1;
         err_at[cyc + 1]  = 0;
         phase = 1;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx_valid = 1'b0;
      start = 1'b0;
      tick();
      rst = 1'b0;
      phase = 0;
      idx = 0;
      tick();
   endtask

   task automatic send_frame(input logic [DW-1:0] base);
      for (int i = 0; i < NPIX; i++) send_byte(base + DW'(i));
   endtask

   int n0, d0, tmo;

   initial begin
      #400000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1);
   end

   initial begin
      // 1: reset release and divider cadence
      tick();
      rst = 1'b0;
      repeat (17) tick();
      chk("rx_en_pattern", {16'd0, pat}, 32'h0000_8888);
      pat_done = 1;
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_rx_reset", {31'd0, rx_reset}, 32'd1);

      // 2: non-sync byte dropped, full frame of 0x00..0x07
      wlog.delete(); n0 = nwr; d0 = ndone;
      pulse_start();
      send_byte(8'h11);
      send_byte(8'hA5);
      send_frame(8'h00);
      repeat (4) tick();
      chk("t2_writes", nwr - n0, 32'd8);
      chk("t2_done_count", ndone - d0, 32'd1);
      chk("t2_addr0", {24'd0, wlog[0]}, 32'h00);
      chk("t2_addr7", {24'd0, wlog[7]}, 32'h07);

      // 3: host stalls after three pixels
      wlog.delete(); n0 = nwr;
      pulse_start();
      send_byte(8'hA5);
      send_byte(8'h21);
      send_byte(8'h22);
      send_byte(8'h23);
      tmo = last_acc + 1;
      while ((tmo % BD) != BD - 1) tmo++;
      tmo = tmo + (TO - 1) * BD;
      busy_at[tmo + 1] = 0;
      err_at[tmo + 1]  = 1;
      phase = 0;
      while (cyc < tmo + 6) tick();
      chk("t3_err_set", {31'd0, err}, 32'd1);
      chk("t3_writes", nwr - n0, 32'd3);
      chk("t3_addr2", {24'd0, wlog[2]}, 32'h23);
      pulse_start();
      chk("t3_err_cleared", {31'd0, err}, 32'd0);
      do_reset();

      // 4: long valid level and a stray start mid-load
      wlog.delete(); n0 = nwr; d0 = ndone;
      pulse_start();
      send_byte(8'hA5);
      send_byte(8'h30, 40);
      pulse_start();
      for (int i = 1; i < NPIX; i++) send_byte(8'h30 + DW'(i));
      repeat (4) tick();
      chk("t4_writes", nwr - n0, 32'd8);
      chk("t4_addr1", {24'd0, wlog[1]}, 32'h31);
      chk("t4_addr7", {24'd0, wlog[7]}, 32'h37);
      chk("t4_done_count", ndone - d0, 32'd1);

      // 5: reset after the write to addr 4, then a fresh full load
      wlog.delete(); d0 = ndone;
      pulse_start();
      send_byte(8'hA5);
      for (int i = 0; i < 5; i++) send_byte(8'h40 + DW'(i));
      chk("t5_pre_addr", {20'd0, wr_addr}, 32'd4);
      rst = 1'b1;
      tick();
      #3;
      chk("t5_rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("t5_rst_wr_addr", {20'd0, wr_addr}, 32'd0);
      chk("t5_rst_rx_reset", {31'd0, rx_reset}, 32'd1);
      chk("t5_rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      phase = 0;
      tick();
      tick();
      wlog.delete(); n0 = nwr;
      pulse_start();
      send_byte(8'hA5);
      send_frame(8'h50);
      repeat (4) tick();
      chk("t5_writes", nwr - n0, 32'd8);
      chk("t5_addr0", {24'd0, wlog[0]}, 32'h50);
      chk("t5_done_count", ndone - d0, 32'd1);

      // 6: sync value inside a frame is an ordinary pixel
      wlog.delete(); n0 = nwr; d0 = ndone;
      pulse_start();
      send_byte(8'hA5);
      send_byte(8'h60);
      send_byte(8'h61);
      send_byte(8'h62);
      send_byte(8'hA5);
      for (int i = 4; i < NPIX; i++) send_byte(8'h60 + DW'(i));
      repeat (4) tick();
      chk("t6_writes", nwr - n0, 32'd8);
      chk("t6_addr3", {24'd0, wlog[3]}, 32'hA5);
      chk("t6_addr7", {24'd0, wlog[7]}, 32'h67);
      chk("t6_done_count", ndone - d0, 32'd1);
      chk("t6_idle", {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_image_loader.md
Name: uart_rx_image_loader

Overview:
Sequences the oversampling UART receiver to load one image into the frame-buffer BRAM.
- Generates the receiver's oversample enable strobe and holds the receiver in reset while idle.
- Waits for a sync byte, then writes IMG_WIDTH*IMG_HEIGHT received bytes to consecutive BRAM addresses.
- Reports done, or a timeout if the host stalls.
- Sits between the receiver and the image-processing frame buffer.

Parameters:
BAUD_DIV, 54, i_clk cycles per oversample tick (o_rx_en period); must be >= 2.
DATA_WIDTH, 8, received byte / pixel width.
IMG_WIDTH, 64, pixels per line.
IMG_HEIGHT, 64, lines per image.
ADDR_WIDTH, 12, BRAM address width; must be >= clog2(IMG_WIDTH*IMG_HEIGHT).
SYNC_BYTE, 8'hA5, byte that opens a frame.
TIMEOUT_TICKS, 4096, o_rx_en ticks allowed between bytes in LOAD.

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_start  in  1  arm a load; single-cycle pulse, honoured only in IDLE
o_rx_en  out  1  oversample enable strobe to receiver
o_rx_reset  out  1  reset to receiver
i_rx_data  in  DATA_WIDTH  receiver byte
i_rx_data_valid  in  1  receiver valid; level, held for a whole tick window
o_wr_en  out  1  BRAM write strobe
o_wr_addr  out  ADDR_WIDTH  BRAM write address
o_wr_data  out  DATA_WIDTH  BRAM write data
o_busy  out  1  high in SYNC and LOAD
o_done  out  1  one-cycle pulse when the last pixel is written
o_err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset values (i_reset=1): state IDLE; o_wr_en=0, o_wr_addr=0, o_wr_data=0; o_done=0, o_err_timeout=0, o_busy=0; o_rx_reset=1; divider count 0.
- Divider:
  - Free-running counter 0..BAUD_DIV-1; o_rx_en=1 exactly when count==BAUD_DIV-1, giving one pulse every BAUD_DIV cycles.
  - Runs in every state, because the receiver only applies its reset while o_rx_en is high.
- Byte accept:
  - valid_q is i_rx_data_valid registered each cycle.
  - accept = i_rx_data_valid & !valid_q (rising edge). One accept per valid level, however many cycles it lasts.
  - i_rx_data is sampled in the accept cycle.
- o_rx_reset = 1 in IDLE and DONE, 0 in SYNC and LOAD.
- States:
  - IDLE: i_start -> SYNC, clearing o_err_timeout and setting address = 0.
  - SYNC: accept with data==SYNC_BYTE -> LOAD. Other bytes are discarded. No timeout in SYNC.
  - LOAD, per accept:
    - Next cycle: o_wr_en=1 for one cycle, o_wr_data = captured byte, o_wr_addr = current pixel index.
    - Address increments after the write.
    - The byte written at index IMG_WIDTH*IMG_HEIGHT-1 -> DONE.
    - SYNC_BYTE values in LOAD are ordinary pixels.
  - LOAD timeout:
    - Tick counter is cleared on each accept and on entry to LOAD, and increments on each o_rx_en.
    - Reaching TIMEOUT_TICKS -> set o_err_timeout, go to IDLE, no further writes.
  - DONE: o_done=1 for exactly one cycle, then IDLE.
- Latency: write strobe 1 cycle after accept; o_done in the cycle after the last o_wr_en.
- Address arithmetic: pixel index width ADDR_WIDTH. Last index = IMG_WIDTH*IMG_HEIGHT-1. No wrap inside a frame.
- Simultaneous events:
  - i_start outside IDLE is ignored.
  - accept in the same cycle as a timeout: the accept wins, the counter clears, no error.
  - i_reset has priority over everything; reset mid-LOAD drops any pending write and returns to IDLE.
- o_err_timeout holds until the next accepted i_start or i_reset.

Test Plan:
(Bench params: BAUD_DIV=4, IMG_WIDTH=4, IMG_HEIGHT=2, TIMEOUT_TICKS=20.)
1. Reset released, 16 cycles -> o_rx_en pulses on cycles 3, 7, 11, 15; o_rx_reset=1; o_busy=0; no o_wr_en.
2. i_start, bytes 0x11, 0xA5, then 0x00..0x07, each valid held 8 cycles:
   - 0x11 is dropped.
   - Exactly 8 writes, addr 0..7, data 0x00..0x07, each 1 cycle after its valid edge.
   - o_done one cycle after the addr-7 write, then IDLE.
3. i_start, 0xA5, 3 pixels, then silence -> o_err_timeout=1 after 20 ticks; no writes beyond addr 2; a new i_start clears the flag.
4. Valid held high for 40 cycles in LOAD -> exactly one write; i_start pulsed mid-LOAD -> no effect on state or address.
5. i_reset asserted after the write to addr 4 -> next cycle: IDLE, o_wr_en=0, o_wr_addr=0, o_rx_reset=1; a fresh load completes with addresses restarting at 0.
6. Pixel value 0xA5 in LOAD -> written as data at its own address; frame still ends at addr 7.
